pe_data_fifo_v2: RTL and testbench

Parametrised first-word-fall-through FIFO buffering data between a PE's internal datapath and the cluster interconnect. It adds to the first-generation PE data FIFO:

- configurable width and depth;
- true two-sided valid/ready backpressure;
- an optional zero-latency bypass path when empty;
- synchronous flush;
- occupancy, almost-full and high-water-mark status for the cluster controller.

One instance sits on each PE data port (ifmap, weight, psum in/out).

---
 rtl/pe_pkg.sv | 23 ++
 rtl/pe_fifo_ptr.sv | 25 ++
 rtl/pe_data_fifo_v2.sv | 117 +++++++++++
 tb/tb_pe_data_fifo_v2.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE definitions: default FIFO depth, per-port payload widths and
// the occupancy-counter width helper used by the PE data FIFOs.
package pe_pkg;

    localparam int unsigned PE_FIFO_DEPTH_DEFAULT = 4;

    localparam int unsigned PE_IFMAP_W  = 8;
    localparam int unsigned PE_WEIGHT_W = 8;
    localparam int unsigned PE_PSUM_W   = 24;

    typedef enum logic [1:0] {
        PE_PORT_IFMAP    = 2'd0,
        PE_PORT_WEIGHT   = 2'd1,
        PE_PORT_PSUM_IN  = 2'd2,
        PE_PORT_PSUM_OUT = 2'd3
    } pe_port_e;

    // Counter must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int unsigned pe_cnt_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pe_fifo_ptr.sv
// Wrap-around pointer with increment enable and synchronous clear; wraps
// modulo 2**WIDTH, which matches a power-of-two FIFO depth.
module pe_fifo_ptr #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_ptr
);

    logic [WIDTH-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= r_ptr + WIDTH'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/pe_data_fifo_v2.sv
// First-word-fall-through PE data FIFO with valid/ready on both sides,
// optional empty bypass, synchronous flush and occupancy/high-water status.
module pe_data_fifo_v2
    import pe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 4,
    parameter int unsigned DEPTH       = PE_FIFO_DEPTH_DEFAULT,
    parameter bit          BYPASS      = 1'b1,
    parameter int unsigned AFULL_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [pe_cnt_w(DEPTH)-1:0]   count,
    output logic                         almost_full,
    output logic [pe_cnt_w(DEPTH)-1:0]   high_water
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = pe_cnt_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_high_water;
    logic [CW-1:0]         w_count_nxt;
    logic [PW-1:0]         w_rd_ptr;
    logic [PW-1:0]         w_wr_ptr;

    logic w_block;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_pass;
    logic w_push_st;
    logic w_pop_st;

    assign w_block = rst | flush;
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // in_ready depends only on registered state and the clear inputs, never on out_ready.
    assign in_ready = ~w_full & ~w_block;

    always_comb begin
        out_valid = 1'b0;
        out_data  = r_mem[w_rd_ptr];
        if (w_empty) begin
            if (BYPASS) begin
                out_valid = in_valid & ~w_block;
                out_data  = in_data;
            end
        end else begin
            out_valid = ~w_block;
        end
    end

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // A bypassed word is handed straight to the consumer and never touches storage.
    assign w_pass    = BYPASS & w_empty & w_push & out_ready;
    assign w_push_st = w_push & ~w_pass;
    assign w_pop_st  = w_pop & ~w_pass;

    assign w_count_nxt = r_count + CW'(w_push_st) - CW'(w_pop_st);

    always_ff @(posedge clk) begin
        if (w_block) begin
            r_count      <= '0;
            r_high_water <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_count_nxt > r_high_water) begin
                r_high_water <= w_count_nxt;
            end
        end
    end

    // Storage is deliberately left unreset; it is unobservable while empty.
    always_ff @(posedge clk) begin
        if (w_push_st) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    pe_fifo_ptr #(
        .WIDTH (PW)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_en  (w_pop_st),
        .o_ptr (w_rd_ptr)
    );

    pe_fifo_ptr #(
        .WIDTH (PW)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .i_clr (flush),
        .i_en  (w_push_st),
        .o_ptr (w_wr_ptr)
    );

    assign count       = r_count;
    assign high_water  = r_high_water;
    assign almost_full = (r_count >= CW'(AFULL_LEVEL));

endmodule

// File: tb/tb_pe_data_fifo_v2.sv
// Directed and randomized checks of pe_data_fifo_v2 in three configurations:
// A = 4x4 bypass, B = 4x4 registered only, C = 8x16 bypass.
module tb_pe_data_fifo_v2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;

    logic       a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_almost_full;
    logic [3:0] a_in_data = 0, a_out_data;
    logic [2:0] a_count, a_high_water;

    logic       b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_almost_full;
    logic [3:0] b_in_data = 0, b_out_data;
    logic [2:0] b_count, b_high_water;

    logic        c_flush = 0, c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_almost_full;
    logic [15:0] c_in_data = 0, c_out_data;
    logic [3:0]  c_count, c_high_water;

    int checks = 0;
    int errors = 0;

    pe_data_fifo_v2 #(.DATA_WIDTH(4), .DEPTH(4), .BYPASS(1'b1), .AFULL_LEVEL(3)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .count(a_count), .almost_full(a_almost_full), .high_water(a_high_water));

    pe_data_fifo_v2 #(.DATA_WIDTH(4), .DEPTH(4), .BYPASS(1'b0), .AFULL_LEVEL(3)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .almost_full(b_almost_full), .high_water(b_high_water));

    pe_data_fifo_v2 #(.DATA_WIDTH(16), .DEPTH(8), .BYPASS(1'b1), .AFULL_LEVEL(7)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .count(c_count), .almost_full(c_almost_full), .high_water(c_high_water));

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_in_valid = 1'b1; a_in_data = 4'h7; a_out_ready = 1'b1; b_in_valid = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL rst_a_in_ready got %b exp 0", a_in_ready); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_out_valid got %b exp 0", a_out_valid); end
        checks++; if (b_in_ready !== 1'b0) begin errors++; $display("FAIL rst_b_in_ready got %b exp 0", b_in_ready); end
        tick();
        rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL post_rst_count got %0d exp 0", a_count); end
        checks++; if (a_almost_full !== 1'b0) begin errors++; $display("FAIL post_rst_afull got %b exp 0", a_almost_full); end
        checks++; if (a_high_water !== 3'd0) begin errors++; $display("FAIL post_rst_hw got %0d exp 0", a_high_water); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got %b exp 1", a_in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_b_in_ready got %b exp 1", b_in_ready); end
        checks++; if (c_count !== 4'd0) begin errors++; $display("FAIL post_rst_c_count got %0d exp 0", c_count); end
    endtask

    task automatic test_bypass();
        tick();
        a_in_valid = 1'b1; a_in_data = 4'h3; a_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got %b exp 1", a_out_valid); end
        checks++; if (a_out_data !== 4'h3) begin errors++; $display("FAIL bypass_data got %h exp 3", a_out_data); end
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL bypass_count got %0d exp 0", a_count); end
        tick();
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_count !== 3'd0) begin errors++; $display("FAIL bypass_count_after got %0d exp 0", a_count); end
        checks++; if (a_high_water !== 3'd0) begin errors++; $display("FAIL bypass_hw got %0d exp 0", a_high_water); end
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bypass_idle_valid got %b exp 0", a_out_valid); end
    endtask

    task automatic test_fill();
        int  got;
        logic acc;
        a_out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            a_in_valid = 1'b1; a_in_data = 4'(i);
            @(negedge clk);
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready[%0d] got %b exp 1", i, a_in_ready); end
            checks++; if (a_count !== 3'(i - 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, a_count, i - 1); end
            checks++; if (a_almost_full !== (i - 1 >= 3)) begin errors++; $display("FAIL fill_afull[%0d] got %b exp %b", i, a_almost_full, (i - 1 >= 3)); end
        end
        tick();
        a_in_data = 4'h5;
        @(negedge clk);
        checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %b exp 0", a_in_ready); end
        checks++; if (a_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", a_count); end
        checks++; if (a_almost_full !== 1'b1) begin errors++; $display("FAIL full_afull got %b exp 1", a_almost_full); end
        checks++; if (a_high_water !== 3'd4) begin errors++; $display("FAIL full_hw got %0d exp 4", a_high_water); end
        tick();
        @(negedge clk);
        checks++; if (a_count !== 3'd4 || a_in_ready !== 1'b0) begin errors++; $display("FAIL full_hold count %0d in_ready %b exp 4 0", a_count, a_in_ready); end
        tick();
        a_out_ready = 1'b1;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL full_pop_in_ready got %b exp 0", a_in_ready); end
            end
            if (a_out_valid) begin
                checks++; if (a_out_data !== 4'(got + 1)) begin errors++; $display("FAIL drain_data[%0d] got %h exp %h", got, a_out_data, 4'(got + 1)); end
                got++;
            end
            acc = a_in_valid & a_in_ready;
            tick();
            if (acc) a_in_valid = 1'b0;
        end
        checks++; if (got != 5) begin errors++; $display("FAIL drain_words got %0d exp 5", got); end
        @(negedge clk);
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty count %0d valid %b exp 0 0", a_count, a_out_valid); end
    endtask

    task automatic test_back_to_back();
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_flush = 1'b1;
        tick();
        a_flush = 1'b0;
        a_in_valid = 1'b1; a_in_data = 4'h0;
        tick();
        a_in_data = 4'h1;
        tick();
        for (int i = 0; i < 16; i++) begin
            a_in_data = 4'(i + 2); a_out_ready = 1'b1;
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b1 || a_out_data !== 4'(i)) begin errors++; $display("FAIL b2b_data[%0d] valid %b got %h exp %h", i, a_out_valid, a_out_data, 4'(i)); end
            checks++; if (a_count !== 3'd2 || a_in_ready !== 1'b1) begin errors++; $display("FAIL b2b_count[%0d] got %0d rdy %b exp 2 1", i, a_count, a_in_ready); end
            tick();
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out_data !== 4'h0 || a_count !== 3'd2) begin errors++; $display("FAIL b2b_tail0 got %h cnt %0d exp 0 2", a_out_data, a_count); end
        tick();
        @(negedge clk);
        checks++; if (a_out_data !== 4'h1 || a_count !== 3'd1) begin errors++; $display("FAIL b2b_tail1 got %h cnt %0d exp 1 1", a_out_data, a_count); end
        tick();
        @(negedge clk);
        checks++; if (a_count !== 3'd0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty cnt %0d valid %b exp 0 0", a_count, a_out_valid); end
        checks++; if (a_high_water !== 3'd2) begin errors++; $display("FAIL b2b_hw got %0d exp 2", a_high_water); end
        a_out_ready = 1'b0;
    endtask

    task automatic test_nobypass();
        tick();
        b_in_valid = 1'b1; b_in_data = 4'hA; b_out_ready = 1'b1;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL nobyp_valid0 got %b exp 0", b_out_valid); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL nobyp_ready got %b exp 1", b_in_ready); end
        tick();
        b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b1 || b_out_data !== 4'hA) begin errors++; $display("FAIL nobyp_head valid %b got %h exp 1 a", b_out_valid, b_out_data); end
        checks++; if (b_count !== 3'd1) begin errors++; $display("FAIL nobyp_count got %0d exp 1", b_count); end
        tick();
        @(negedge clk);
        checks++; if (b_out_valid !== 1'b0 || b_count !== 3'd0) begin errors++; $display("FAIL nobyp_popped valid %b cnt %0d exp 0 0", b_out_valid, b_count); end
        b_out_ready = 1'b0;
    endtask

    task automatic test_flush(input bit use_rst);
        b_out_ready = 1'b0;
        b_in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            b_in_data = 4'(i);
            tick();
        end
        b_in_data = 4'h4;
        if (use_rst) rst = 1'b1; else b_flush = 1'b1;
        @(negedge clk);
        checks++; if (b_count !== 3'd3 || b_high_water !== 3'd3 || b_almost_full !== 1'b1) begin errors++; $display("FAIL clr%0d_pre cnt %0d hw %0d af %b exp 3 3 1", use_rst, b_count, b_high_water, b_almost_full); end
        checks++; if (b_in_ready !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_gate rdy %b valid %b exp 0 0", use_rst, b_in_ready, b_out_valid); end
        tick();
        rst = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0;
        @(negedge clk);
        checks++; if (b_count !== 3'd0 || b_high_water !== 3'd0) begin errors++; $display("FAIL clr%0d_post cnt %0d hw %0d exp 0 0", use_rst, b_count, b_high_water); end
        checks++; if (b_out_valid !== 1'b0 || b_almost_full !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("FAIL clr%0d_status valid %b af %b rdy %b exp 0 0 1", use_rst, b_out_valid, b_almost_full, b_in_ready); end
        tick();
        @(negedge clk);
        checks++; if (b_count !== 3'd0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL clr%0d_nopush cnt %0d valid %b exp 0 0", use_rst, b_count, b_out_valid); end
    endtask

    task automatic test_random();
        logic [15:0] q[$];
        logic [15:0] exp_w;
        logic pushed_last;
        logic push, pop;
        pushed_last = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            if (!(c_in_valid && !pushed_last)) begin
                c_in_valid = 1'($urandom_range(0, 1));
                c_in_data  = 16'($urandom);
            end
            c_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++; if (c_count !== 4'(q.size()) || c_count > 4'd8) begin errors++; $display("FAIL rnd_count[%0d] got %0d exp %0d", cyc, c_count, q.size()); end
            checks++; if (c_in_ready !== (q.size() != 8)) begin errors++; $display("FAIL rnd_in_ready[%0d] got %b exp %b", cyc, c_in_ready, (q.size() != 8)); end
            if (q.size() > 0) begin
                checks++; if (c_out_valid !== 1'b1 || c_out_data !== q[0]) begin errors++; $display("FAIL rnd_head[%0d] valid %b got %h exp %h", cyc, c_out_valid, c_out_data, q[0]); end
            end else begin
                checks++; if (c_out_valid !== c_in_valid) begin errors++; $display("FAIL rnd_bypass_valid[%0d] got %b exp %b", cyc, c_out_valid, c_in_valid); end
            end
            push = c_in_valid & c_in_ready;
            pop  = c_out_valid & c_out_ready;
            if (push) q.push_back(c_in_data);
            if (pop) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rnd_underflow[%0d] got %h exp none", cyc, c_out_data);
                end else begin
                    exp_w = q.pop_front();
                    if (c_out_data !== exp_w) begin errors++; $display("FAIL rnd_pop[%0d] got %h exp %h", cyc, c_out_data, exp_w); end
                end
            end
            pushed_last = push;
        end
        tick();
        c_in_valid = 1'b0; c_out_ready = 1'b1;
        for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) begin
            @(negedge clk);
            if (c_out_valid) begin
                exp_w = q.pop_front();
                checks++; if (c_out_data !== exp_w) begin errors++; $display("FAIL rnd_drain got %h exp %h", c_out_data, exp_w); end
            end
            tick();
        end
        @(negedge clk);
        checks++; if (q.size() != 0 || c_count !== 4'd0) begin errors++; $display("FAIL rnd_final left %0d cnt %0d exp 0 0", q.size(), c_count); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_fill();
        test_back_to_back();
        test_nobypass();
        test_flush(1'b0);
        test_flush(1'b1);
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
